// File: rtl/dma_block_writer.sv
// dma_block_writer: moves device blocks into memory as one burst per block.
// The CPU issues a base address and block count. The engine requests the
// bus, walks the device offsets, writes each block as a single burst, and
// then pulses dma_end. Every output is decoded from the state register or
// held in a register, so no input reaches an output combinationally.
module dma_block_writer #(
  parameter int WORD_SIZE   = 16,
  parameter int BLOCK_WORDS = 4,
  parameter int MAX_BLOCKS  = 3,
  parameter int OFFSET_W    = 2,
  parameter int LEN_W       = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            cmd_valid,
  input  logic [WORD_SIZE-1:0]            cmd_addr,
  input  logic [LEN_W-1:0]                cmd_length,
  input  logic                            bg,
  output logic                            br,
  output logic [OFFSET_W-1:0]             dev_offset,
  input  logic [WORD_SIZE*BLOCK_WORDS-1:0] dev_data,
  output logic                            mem_write,
  output logic [WORD_SIZE-1:0]            mem_addr,
  output logic [WORD_SIZE*BLOCK_WORDS-1:0] mem_data,
  input  logic                            mem_ack,
  output logic                            dma_end,
  output logic                            busy
);

  localparam int DATA_W = WORD_SIZE * BLOCK_WORDS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_LOAD,
    S_CAPT,
    S_WRITE,
    S_NEXT,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [WORD_SIZE-1:0] r_addr;
  logic [LEN_W-1:0]     r_len;
  logic [LEN_W-1:0]     r_blk;
  logic [WORD_SIZE-1:0] r_mem_addr;
  logic [DATA_W-1:0]    r_mem_data;

  logic [LEN_W-1:0]     w_len_clamped;
  logic [LEN_W-1:0]     w_blk_inc;
  logic [WORD_SIZE-1:0] w_burst_addr;

  // Requested length saturates at the device depth.
  assign w_len_clamped = (cmd_length > LEN_W'(MAX_BLOCKS)) ? LEN_W'(MAX_BLOCKS)
                                                           : cmd_length;
  assign w_blk_inc     = r_blk + LEN_W'(1);
  // Burst base address; wraps modulo 2^WORD_SIZE by construction.
  assign w_burst_addr  = r_addr + (WORD_SIZE'(r_blk) * WORD_SIZE'(BLOCK_WORDS));

  // State register.
  // NOTE: clocked blocks use non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  // NOTE: the default assignment first guarantees a value on every path,
  // so no latch is inferred when a case arm leaves the signal untouched.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_next_state = (w_len_clamped == '0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (bg) begin
          w_next_state = S_LOAD;
        end
      end
      S_LOAD:  w_next_state = S_CAPT;
      S_CAPT:  w_next_state = S_WRITE;
      S_WRITE: begin
        // Bus grant is deliberately ignored: a started burst always completes.
        if (mem_ack) begin
          w_next_state = S_NEXT;
        end
      end
      S_NEXT: begin
        if (w_blk_inc == r_len) begin
          w_next_state = S_DONE;
        end else if (bg) begin
          w_next_state = S_LOAD;
        end else begin
          // CPU reclaimed the bus between blocks; ask for it again.
          w_next_state = S_REQ;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Command latch, block counter and burst address/data registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr     <= '0;
      r_len      <= '0;
      r_blk      <= '0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_addr <= cmd_addr;
            r_len  <= w_len_clamped;
            r_blk  <= '0;
          end
        end
        S_CAPT: begin
          // Device data has had the whole LOAD cycle to settle.
          r_mem_data <= dev_data;
          r_mem_addr <= w_burst_addr;
        end
        S_NEXT: begin
          r_blk <= w_blk_inc;
        end
        default: begin
        end
      endcase
    end
  end

  // Moore outputs: bus is requested and held from REQ through NEXT.
  assign br         = (r_state == S_REQ)  || (r_state == S_LOAD) ||
                      (r_state == S_CAPT) || (r_state == S_WRITE) ||
                      (r_state == S_NEXT);
  // Offset is presented only while the device is being read; all ones
  // otherwise so the device tristates its data.
  assign dev_offset = ((r_state == S_LOAD) || (r_state == S_CAPT))
                      ? r_blk[OFFSET_W-1:0] : '1;
  assign mem_write  = (r_state == S_WRITE);
  assign mem_addr   = r_mem_addr;
  assign mem_data   = r_mem_data;
  assign dma_end    = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);

endmodule

// File: doc/dma_block_writer.md
Name: dma_block_writer

Overview:
- DMA engine directly downstream of the interrupt-driven external device.
- The CPU responds to the device interrupt by issuing a command: destination address plus block count. The engine then requests the bus and walks the device offsets.
- Each 64-bit (4-word) device block is written to memory as one burst. The engine releases the bus and signals completion to the CPU.

Parameters:
WORD_SIZE, 16, bits per memory word
BLOCK_WORDS, 4, words per device block; data width = WORD_SIZE*BLOCK_WORDS
MAX_BLOCKS, 3, device storage depth; larger lengths are clamped to this
OFFSET_W, 2, device offset width
LEN_W, 4, command length width

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  one-cycle start pulse from CPU
cmd_addr  in  WORD_SIZE  destination base word address
cmd_length  in  LEN_W  number of blocks to move
bg  in  1  bus grant from CPU
br  out  1  bus request to CPU
dev_offset  out  OFFSET_W  block index driven to external device
dev_data  in  WORD_SIZE*BLOCK_WORDS  block data returned combinationally by device
mem_write  out  1  memory write strobe
mem_addr  out  WORD_SIZE  burst base word address
mem_data  out  WORD_SIZE*BLOCK_WORDS  burst write data
mem_ack  in  1  memory completed current burst
dma_end  out  1  one-cycle completion pulse to CPU
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, reset_n=0): state IDLE.
  - br=0, mem_write=0, dma_end=0, busy=0.
  - dev_offset=all ones (device drives Z).
  - mem_addr=0, mem_data=0.
  - Internal counters cleared.
- Reset asserted mid-transfer aborts immediately to these values. No dma_end is produced.
- All outputs are registered or decoded from the state register (Moore). No combinational path from inputs to outputs.
- FSM:
  - IDLE: on cmd_valid, latch addr and len = min(cmd_length, MAX_BLOCKS), set blk=0.
    - len=0 -> DONE.
    - Otherwise -> REQ.
    - cmd_valid in any other state is ignored.
  - REQ: br=1. bg=1 sampled -> LOAD.
  - LOAD: br=1, dev_offset=blk. This cycle gives the device data time to settle. -> CAPT.
  - CAPT: mem_data<=dev_data, mem_addr<=addr+blk*BLOCK_WORDS (modulo 2^WORD_SIZE, wraps). -> WRITE.
  - WRITE: mem_write=1 with addr and data held stable.
    - Stays here until mem_ack=1 is sampled.
    - bg dropping here is ignored; the burst always completes.
  - NEXT: mem_write=0, blk<=blk+1.
    - blk+1==len -> DONE.
    - Else bg=1 -> LOAD.
    - Else -> REQ (cycle stealing: the CPU may reclaim the bus between blocks).
  - DONE: br=0, dev_offset=all ones, dma_end=1 for exactly one cycle. -> IDLE.
- Timing:
  - cmd_valid at edge k gives br=1 in the cycle after edge k.
  - bg held high and mem_ack returned one cycle after mem_write rises gives 4 cycles per block (LOAD, CAPT, WRITE, NEXT).
  - Completion: DONE follows the final NEXT.
- Simultaneous mem_ack and bg fall in WRITE: the burst completes, then NEXT re-enters REQ.
- mem_ack outside WRITE is ignored.

Test Plan:
1. Reset mid-WRITE (reset_n=0 for 1 cycle) -> all outputs return to reset values immediately; dev_offset=2'b11; no dma_end; next cmd_valid starts cleanly.
2. cmd_addr=16'h0100, cmd_length=3, bg tied high, mem_ack one cycle after mem_write -> three bursts at 0x0100/0x0104/0x0108 carrying the device words for offsets 0/1/2; dma_end pulses once, 13 cycles after br rises; br=0 afterwards.
3. cmd_length=5 -> clamped to 3 bursts; cmd_length=0 -> dma_end one cycle after IDLE exits, with br never asserted and no mem_write.
4. bg low for 10 cycles after the first NEXT -> br stays 1, no dev_offset change or mem_write until bg returns; the second burst then goes to 0x0104.
5. mem_ack delayed 5 cycles -> mem_write, mem_addr and mem_data stable throughout; no double write. A cmd_valid pulse during the transfer is ignored.
6. cmd_addr=16'hFFFC, cmd_length=2 -> second burst address wraps to 16'h0000.
